// File: rtl/bp_pkg.sv
// Shared types for the gshare PHT update controller: FSM states, 2-bit counter
// encodings, in-flight queue entry layout and the saturating counter update.
package bp_pkg;

    // Sizes the queue entry; the controller's IDX_W must equal this value.
    localparam int unsigned BP_IDX_W = 4;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        RECOVER
    } bp_state_t;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic [1:0]          ctr;
        logic                pred;
        logic [BP_IDX_W-1:0] ghr_snap;
    } bp_entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// Synchronous FIFO holding in-flight branch records from fetch to resolve,
// with a combinational head and a clear that squashes all entries.
module bp_inflight_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// gshare PHT controller: init sweep, speculative GHR and read index at fetch,
// in-flight branch tracking, counter write-back and mispredict GHR repair.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned SIZE     = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned DEPTH    = 4,
    parameter logic [1:0]  INIT_VAL = 2'b11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_valid,
    input  logic             f_is_branch,
    input  logic [IDX_W-1:0] f_pc,
    output logic [IDX_W-1:0] pht_raddr,
    input  logic [1:0]       pht_rdata,
    output logic             f_pred_taken,
    output logic             f_ready,
    input  logic             e_valid,
    input  logic             e_is_branch,
    input  logic             e_taken,
    output logic             pht_we,
    output logic [IDX_W-1:0] pht_waddr,
    output logic [1:0]       pht_wdata,
    output logic             flush,
    output logic [IDX_W-1:0] ghr,
    output logic             init_busy,
    output logic             err_underflow
);

    bp_state_t        state;
    logic [IDX_W-1:0] init_cnt;
    logic [IDX_W-1:0] ghr_q;
    logic             err_q;
    logic             busy_q;

    bp_entry_t        push_entry;
    bp_entry_t        head_entry;
    logic             q_full;
    logic             q_empty;

    logic             resolve;
    logic             pop;
    logic             push;
    logic             mispredict;

    assign ghr           = ghr_q;
    assign init_busy     = busy_q;
    assign err_underflow = err_q;

    assign pht_raddr     = ghr_q ^ f_pc;
    assign f_ready       = (state == RUN) & ~q_full;
    assign f_pred_taken  = f_valid & f_is_branch & pht_rdata[1] & f_ready;

    assign resolve    = (state != INIT) & e_valid & e_is_branch;
    assign pop        = resolve & ~q_empty;
    assign mispredict = pop & (head_entry.pred != e_taken);
    assign flush      = mispredict;
    // A mispredict squashes the queue, so a fetch offered alongside it is dropped.
    assign push       = f_valid & f_is_branch & f_ready & ~mispredict;

    always_comb begin
        push_entry.idx      = pht_raddr;
        push_entry.ctr      = pht_rdata;
        push_entry.pred     = pht_rdata[1];
        push_entry.ghr_snap = ghr_q;
    end

    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = '0;
        pht_wdata = '0;
        if (state == INIT) begin
            pht_we    = 1'b1;
            pht_waddr = init_cnt;
            pht_wdata = INIT_VAL;
        end else if (pop) begin
            pht_we    = 1'b1;
            pht_waddr = head_entry.idx;
            pht_wdata = sat_update(head_entry.ctr, e_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
            ghr_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == IDX_W'(SIZE - 1)) begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (mispredict) begin
                        ghr_q <= IDX_W'({head_entry.ghr_snap, e_taken});
                        state <= RECOVER;
                    end else if (push) begin
                        ghr_q <= IDX_W'({ghr_q, pht_rdata[1]});
                    end
                end
                RECOVER: state <= RUN;
                default: state <= INIT;
            endcase
            if (resolve && q_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    bp_inflight_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(bp_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (mispredict),
        .din   (push_entry),
        .head  (head_entry),
        .full  (q_full),
        .empty (q_empty)
    );

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_bp_update_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       f_valid = 1'b0, f_is_branch = 1'b0;
    logic [3:0] f_pc = '0;
    logic [3:0] pht_raddr;
    logic [1:0] pht_rdata;
    logic       f_pred_taken, f_ready;
    logic       e_valid = 1'b0, e_is_branch = 1'b0, e_taken = 1'b0;
    logic       pht_we;
    logic [3:0] pht_waddr;
    logic [1:0] pht_wdata;
    logic       flush;
    logic [3:0] ghr;
    logic       init_busy, err_underflow;

    logic [1:0] pht_mem [16];
    assign pht_rdata = pht_mem[pht_raddr];

    always #5 clk = ~clk;

    bp_update_ctrl #(
        .SIZE     (16),
        .IDX_W    (4),
        .DEPTH    (4),
        .INIT_VAL (2'b11)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .f_valid       (f_valid),
        .f_is_branch   (f_is_branch),
        .f_pc          (f_pc),
        .pht_raddr     (pht_raddr),
        .pht_rdata     (pht_rdata),
        .f_pred_taken  (f_pred_taken),
        .f_ready       (f_ready),
        .e_valid       (e_valid),
        .e_is_branch   (e_is_branch),
        .e_taken       (e_taken),
        .pht_we        (pht_we),
        .pht_waddr     (pht_waddr),
        .pht_wdata     (pht_wdata),
        .flush         (flush),
        .ghr           (ghr),
        .init_busy     (init_busy),
        .err_underflow (err_underflow)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       fv, fb;
        logic [3:0] pc;
        logic       ev, eb, et;
        logic [3:0] raddr;
        logic       pred, ready, we;
        logic [3:0] waddr;
        logic [1:0] wdata;
        logic       flush;
        logic [3:0] ghr;
    } vec_t;

    typedef struct {
        int idx;
        int ctr;
        bit pred;
        int snap;
    } ent_t;

    vec_t tbl [23];

    int   m_init;
    int   m_ghr;
    bit   m_rec;
    bit   m_err;
    ent_t mq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fv, input logic fb, input logic [3:0] pc,
                         input logic ev, input logic eb, input logic et);
        f_valid = fv; f_is_branch = fb; f_pc = pc;
        e_valid = ev; e_is_branch = eb; e_taken = et;
    endtask

    // Called at the negedge; acts as the PHT storage for the coming edge.
    task automatic finish_cycle();
        logic       cwe;
        logic [3:0] cwa;
        logic [1:0] cwd;
        cwe = pht_we; cwa = pht_waddr; cwd = pht_wdata;
        @(posedge clk);
        if (cwe) pht_mem[cwa] = cwd;
        #1;
    endtask

    task automatic reset_and_sweep();
        drive(1, 1, 4'd3, 1, 1, 1);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            finish_cycle();
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("init_busy", init_busy, 1);
            chk("init_we", pht_we, 1);
            chk("init_waddr", pht_waddr, i);
            chk("init_wdata", pht_wdata, 3);
            chk("init_ready", f_ready, 0);
            chk("init_pred", f_pred_taken, 0);
            chk("init_flush", flush, 0);
            chk("init_ghr", ghr, 0);
            chk("init_err", err_underflow, 0);
            finish_cycle();
        end
        drive(0, 0, 4'd0, 0, 0, 0);
        @(negedge clk);
        chk("post_init_busy", init_busy, 0);
        chk("post_init_ready", f_ready, 1);
        chk("post_init_ghr", ghr, 0);
        chk("post_init_we", pht_we, 0);
        finish_cycle();
    endtask

    function automatic int sat(input int c, input bit taken);
        if (taken) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) pht_mem[i] = 2'b00;

        //             fv fb pc    ev eb et  raddr pred rdy we waddr wdata fl ghr
        tbl[0]  = '{1, 1, 4'd5, 0, 0, 0, 4'd5,  1, 1, 0, 4'd0,  2'd0, 0, 4'd0};
        tbl[1]  = '{0, 0, 4'd0, 1, 1, 1, 4'd1,  0, 1, 1, 4'd5,  2'd3, 0, 4'd1};
        tbl[2]  = '{1, 1, 4'd0, 0, 0, 0, 4'd1,  1, 1, 0, 4'd0,  2'd0, 0, 4'd1};
        tbl[3]  = '{0, 0, 4'd0, 1, 1, 1, 4'd3,  0, 1, 1, 4'd1,  2'd3, 0, 4'd3};
        tbl[4]  = '{1, 1, 4'd8, 0, 0, 0, 4'd11, 1, 1, 0, 4'd0,  2'd0, 0, 4'd3};
        tbl[5]  = '{1, 1, 4'd0, 1, 1, 0, 4'd7,  1, 1, 1, 4'd11, 2'd1, 1, 4'd7};
        tbl[6]  = '{1, 1, 4'd0, 0, 0, 0, 4'd6,  0, 0, 0, 4'd0,  2'd0, 0, 4'd6};
        tbl[7]  = '{0, 0, 4'd0, 0, 0, 0, 4'd6,  0, 1, 0, 4'd0,  2'd0, 0, 4'd6};
        tbl[8]  = '{1, 1, 4'd0, 0, 0, 0, 4'd6,  0, 1, 0, 4'd0,  2'd0, 0, 4'd6};
        tbl[9]  = '{0, 0, 4'd0, 1, 1, 0, 4'd12, 0, 1, 1, 4'd6,  2'd0, 0, 4'd12};
        tbl[10] = '{1, 1, 4'd0, 0, 0, 0, 4'd12, 1, 1, 0, 4'd0,  2'd0, 0, 4'd12};
        tbl[11] = '{1, 1, 4'd0, 0, 0, 0, 4'd9,  1, 1, 0, 4'd0,  2'd0, 0, 4'd9};
        tbl[12] = '{1, 1, 4'd0, 0, 0, 0, 4'd3,  1, 1, 0, 4'd0,  2'd0, 0, 4'd3};
        tbl[13] = '{1, 1, 4'd0, 0, 0, 0, 4'd7,  1, 1, 0, 4'd0,  2'd0, 0, 4'd7};
        tbl[14] = '{1, 1, 4'd0, 0, 0, 0, 4'd15, 0, 0, 0, 4'd0,  2'd0, 0, 4'd15};
        tbl[15] = '{1, 1, 4'd0, 1, 1, 1, 4'd15, 0, 0, 1, 4'd12, 2'd3, 0, 4'd15};
        tbl[16] = '{1, 1, 4'd0, 1, 1, 1, 4'd15, 1, 1, 1, 4'd9,  2'd3, 0, 4'd15};
        tbl[17] = '{1, 1, 4'd0, 0, 0, 0, 4'd15, 1, 1, 0, 4'd0,  2'd0, 0, 4'd15};
        tbl[18] = '{1, 1, 4'd0, 0, 0, 0, 4'd15, 0, 0, 0, 4'd0,  2'd0, 0, 4'd15};
        tbl[19] = '{0, 0, 4'd0, 1, 1, 1, 4'd15, 0, 0, 1, 4'd3,  2'd3, 0, 4'd15};
        tbl[20] = '{0, 0, 4'd0, 1, 1, 1, 4'd15, 0, 1, 1, 4'd7,  2'd3, 0, 4'd15};
        tbl[21] = '{0, 0, 4'd0, 1, 1, 1, 4'd15, 0, 1, 1, 4'd15, 2'd3, 0, 4'd15};
        tbl[22] = '{0, 0, 4'd0, 1, 1, 1, 4'd15, 0, 1, 1, 4'd15, 2'd3, 0, 4'd15};

        #1;
        reset_and_sweep();

        // Table: every entry holds 11 after the sweep, except these two.
        pht_mem[11] = 2'b10;
        pht_mem[6]  = 2'b00;
        for (int r = 0; r < 23; r++) begin
            drive(tbl[r].fv, tbl[r].fb, tbl[r].pc, tbl[r].ev, tbl[r].eb, tbl[r].et);
            @(negedge clk);
            chk($sformatf("row%0d_raddr", r), pht_raddr, tbl[r].raddr);
            chk($sformatf("row%0d_pred", r), f_pred_taken, tbl[r].pred);
            chk($sformatf("row%0d_ready", r), f_ready, tbl[r].ready);
            chk($sformatf("row%0d_we", r), pht_we, tbl[r].we);
            if (tbl[r].we) begin
                chk($sformatf("row%0d_waddr", r), pht_waddr, tbl[r].waddr);
                chk($sformatf("row%0d_wdata", r), pht_wdata, tbl[r].wdata);
            end
            chk($sformatf("row%0d_flush", r), flush, tbl[r].flush);
            chk($sformatf("row%0d_ghr", r), ghr, tbl[r].ghr);
            finish_cycle();
        end

        // Resolve against an empty queue: no write, sticky error.
        drive(0, 0, 4'd0, 1, 1, 1);
        @(negedge clk);
        chk("uf_we", pht_we, 0);
        chk("uf_flush", flush, 0);
        chk("uf_err_before", err_underflow, 0);
        finish_cycle();
        drive(0, 0, 4'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("uf_err_held", err_underflow, 1);
            finish_cycle();
        end

        // Reset with two branches in flight: sweep restarts and the queue is gone.
        drive(1, 1, 4'd2, 0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            finish_cycle();
        end
        reset_and_sweep();
        drive(0, 0, 4'd0, 1, 1, 0);
        @(negedge clk);
        chk("rst_queue_cleared_we", pht_we, 0);
        chk("rst_queue_cleared_flush", flush, 0);
        finish_cycle();

        // Randomized traffic against the reference model.
        reset_and_sweep();
        for (int i = 0; i < 16; i++) pht_mem[i] = 2'($urandom_range(0, 3));
        m_init = 0; m_ghr = 0; m_rec = 0; m_err = 0; mq.delete();
        for (int n = 0; n < 3000; n++) begin
            logic       r_fv, r_fb, r_ev, r_eb, r_et, r_rst;
            logic [3:0] r_pc;
            int e_raddr, e_rdata, e_we, e_waddr, e_wdata, e_ready, e_pred, e_flush, e_busy;
            bit pop_ok, uf, push_ok;
            ent_t h;

            r_rst = ($urandom_range(0, 299) == 0);
            r_fv  = ($urandom_range(0, 9) < 7);
            r_fb  = ($urandom_range(0, 9) < 6);
            r_pc  = 4'($urandom_range(0, 15));
            r_ev  = ($urandom_range(0, 9) < 4);
            r_eb  = ($urandom_range(0, 9) < 7);
            r_et  = 1'($urandom_range(0, 1));
            drive(r_fv, r_fb, r_pc, r_ev, r_eb, r_et);
            rst = r_rst;

            e_we = 0; e_waddr = 0; e_wdata = 0; e_flush = 0;
            pop_ok = 0; uf = 0; push_ok = 0; h = '{0, 0, 0, 0};
            e_raddr = m_ghr ^ int'(r_pc);
            e_rdata = int'(pht_mem[e_raddr]);
            e_busy  = (m_init > 0);
            if (m_init > 0) begin
                e_ready = 0;
                e_we = 1; e_waddr = 16 - m_init; e_wdata = 3;
            end else begin
                e_ready = (!m_rec && mq.size() < 4);
                if (r_ev && r_eb) begin
                    if (mq.size() > 0) begin
                        pop_ok = 1;
                        h = mq[0];
                        e_we = 1; e_waddr = h.idx; e_wdata = sat(h.ctr, r_et);
                        e_flush = (h.pred != r_et);
                    end else begin
                        uf = 1;
                    end
                end
            end
            e_pred  = (r_fv && r_fb && e_ready && e_rdata >= 2);
            push_ok = (r_fv && r_fb && e_ready && !e_flush);

            @(negedge clk);
            chk("rnd_raddr", pht_raddr, e_raddr);
            chk("rnd_pred", f_pred_taken, e_pred);
            chk("rnd_ready", f_ready, e_ready);
            chk("rnd_we", pht_we, e_we);
            if (e_we != 0) begin
                chk("rnd_waddr", pht_waddr, e_waddr);
                chk("rnd_wdata", pht_wdata, e_wdata);
            end
            chk("rnd_flush", flush, e_flush);
            chk("rnd_ghr", ghr, m_ghr);
            chk("rnd_busy", init_busy, e_busy);
            chk("rnd_err", err_underflow, m_err);

            if (r_rst) begin
                m_init = 16; m_ghr = 0; m_rec = 0; m_err = 0; mq.delete();
            end else if (m_init > 0) begin
                m_init--;
            end else begin
                if (uf) m_err = 1;
                if (m_rec) begin
                    m_rec = 0;
                end else if (e_flush != 0) begin
                    m_ghr = ((h.snap * 2) + int'(r_et)) % 16;
                    mq.delete();
                    m_rec = 1;
                end else begin
                    if (pop_ok) void'(mq.pop_front());
                    if (push_ok) begin
                        mq.push_back('{e_raddr, e_rdata, (e_rdata >= 2), m_ghr});
                        m_ghr = ((m_ghr * 2) + ((e_rdata >= 2) ? 1 : 0)) % 16;
                    end
                end
            end
            finish_cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
